// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: multi-cycle LDM/STM engine, one register per cycle.
// Ports: clk/reset (sync, active-high); i_start + request fields
//   (i_is_load, i_pre, i_up, i_wback, i_base_reg, i_base_val, i_reg_list);
//   register-file port (o_rf_raddr/i_rf_rdata, o_rf_we/o_rf_waddr/o_rf_wdata);
//   memory port (o_mem_re, o_mem_we, o_mem_addr, o_mem_wdata, i_mem_rdata);
//   status o_busy, o_done.
// Optional macro SEQ_PC_REDIRECT_EN adds o_pc_redir/o_pc_target; a loaded
//   R15 then redirects the PC instead of writing the register file.
module ldm_stm_sequencer #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  logic          i_is_load,
  input  logic          i_pre,
  input  logic          i_up,
  input  logic          i_wback,
  input  logic [3:0]    i_base_reg,
  input  logic [DW-1:0] i_base_val,
  input  logic [15:0]   i_reg_list,
  output logic [3:0]    o_rf_raddr,
  input  logic [DW-1:0] i_rf_rdata,
  output logic          o_rf_we,
  output logic [3:0]    o_rf_waddr,
  output logic [DW-1:0] o_rf_wdata,
  output logic          o_mem_re,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy,
  output logic          o_done
`ifdef SEQ_PC_REDIRECT_EN
  ,
  output logic          o_pc_redir,
  output logic [AW-1:0] o_pc_target
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_WB,
    S_DONE
  } state_t;

  state_t        r_state, w_state_n;

  logic [15:0]   r_mask, w_mask_n;
  logic [AW-1:0] r_addr, w_addr_n;
  logic          r_is_load, w_is_load_n;
  logic          r_wb_en, w_wb_en_n;
  logic [3:0]    r_base_reg, w_base_reg_n;
  logic [DW-1:0] r_wb_val, w_wb_val_n;
  logic          r_pend, w_pend_n;
  logic [3:0]    r_pend_reg, w_pend_reg_n;
  logic [AW-1:0] r_pend_addr, w_pend_addr_n;

  logic [3:0]    r_rf_raddr, w_rf_raddr_n;
  logic          r_rf_we, w_rf_we_n;
  logic [3:0]    r_rf_waddr, w_rf_waddr_n;
  logic [DW-1:0] r_rf_wdata, w_rf_wdata_n;
  logic          r_mem_re, w_mem_re_n;
  logic          r_mem_we, w_mem_we_n;
  logic [AW-1:0] r_mem_addr, w_mem_addr_n;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata_n;
  logic          r_busy, w_busy_n;
  logic          r_done, w_done_n;
`ifdef SEQ_PC_REDIRECT_EN
  logic          r_pc_redir, w_pc_redir_n;
  logic [AW-1:0] r_pc_target, w_pc_target_n;
`endif

  logic [4:0]    w_cnt;
  logic [AW-1:0] w_n4a;
  logic [DW-1:0] w_n4d;
  logic [AW-1:0] w_base;
  logic [AW-1:0] w_start_addr;
  logic [DW-1:0] w_wb_val;
  logic          w_wb_en;
  logic [15:0]   w_cur_mask;
  logic [AW-1:0] w_cur_addr;
  logic          w_cur_load;
  logic [3:0]    w_idx;
  logic          w_issue;
  logic          w_complete;

  // Request decode, valid only while IDLE.
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < 16; i++)
      w_cnt = w_cnt + 5'(i_reg_list[i]);
    w_n4a = AW'({w_cnt, 2'b00});
    w_n4d = DW'({w_cnt, 2'b00});
    w_base = i_base_val[AW-1:0];
    case ({i_pre, i_up})
      2'b01:   w_start_addr = w_base;
      2'b11:   w_start_addr = w_base + AW'(4);
      2'b00:   w_start_addr = w_base - w_n4a + AW'(4);
      default: w_start_addr = w_base - w_n4a;
    endcase
    w_wb_val = i_up ? i_base_val + w_n4d
                    : i_base_val - w_n4d;
    // A loaded base overrides writeback.
    w_wb_en = i_wback && (w_cnt != 5'd0) &&
              !(i_is_load && i_reg_list[i_base_reg]);
  end

  // The first issue happens on the accept edge, so the
  // mask/address come straight from the request in IDLE.
  always_comb begin
    w_cur_mask = (r_state == S_IDLE) ? i_reg_list : r_mask;
    w_cur_addr = (r_state == S_IDLE) ? w_start_addr : r_addr;
    w_cur_load = (r_state == S_IDLE) ? i_is_load : r_is_load;
    w_idx = '0;
    for (int i = 15; i >= 0; i--)
      if (w_cur_mask[i]) w_idx = 4'(i);
  end

  always_comb begin
    w_state_n     = r_state;
    w_mask_n      = r_mask;
    w_addr_n      = r_addr;
    w_is_load_n   = r_is_load;
    w_wb_en_n     = r_wb_en;
    w_base_reg_n  = r_base_reg;
    w_wb_val_n    = r_wb_val;
    w_pend_n      = 1'b0;
    w_pend_reg_n  = r_pend_reg;
    w_pend_addr_n = r_pend_addr;
    w_rf_raddr_n  = '0;
    w_rf_we_n     = 1'b0;
    w_rf_waddr_n  = '0;
    w_rf_wdata_n  = '0;
    w_mem_re_n    = 1'b0;
    w_mem_we_n    = 1'b0;
    w_mem_addr_n  = '0;
    w_mem_wdata_n = '0;
`ifdef SEQ_PC_REDIRECT_EN
    w_pc_redir_n  = 1'b0;
    w_pc_target_n = '0;
`endif
    w_issue       = 1'b0;
    w_complete    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_is_load_n  = i_is_load;
          w_wb_en_n    = w_wb_en;
          w_base_reg_n = i_base_reg;
          w_wb_val_n   = w_wb_val;
          if (i_reg_list == 16'd0) begin
            w_state_n = S_DONE;
          end else begin
            w_state_n = S_XFER;
            w_issue   = 1'b1;
          end
        end
      end
      S_XFER: begin
        w_issue    = |w_cur_mask;
        w_complete = r_pend;
        // Leave only once the last completion has been shown.
        if (!w_issue && !r_pend)
          w_state_n = r_wb_en ? S_WB : S_DONE;
      end
      S_WB: begin
        w_rf_we_n    = 1'b1;
        w_rf_waddr_n = r_base_reg;
        w_rf_wdata_n = r_wb_val;
        w_state_n    = S_DONE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    if (w_issue) begin
      w_pend_n      = 1'b1;
      w_pend_reg_n  = w_idx;
      w_pend_addr_n = w_cur_addr;
      w_mask_n      = w_cur_mask & ~(16'd1 << w_idx);
      w_addr_n      = w_cur_addr + AW'(4);
      if (w_cur_load) begin
        w_mem_re_n   = 1'b1;
        w_mem_addr_n = w_cur_addr;
      end else begin
        w_rf_raddr_n = w_idx;
      end
    end

    // Issue and completion never share a port: a load
    // issue uses mem_addr, a load completion the rf write.
    if (w_complete) begin
      if (r_is_load) begin
`ifdef SEQ_PC_REDIRECT_EN
        if (r_pend_reg == 4'd15) begin
          w_pc_redir_n  = 1'b1;
          w_pc_target_n = {i_mem_rdata[AW-1:2], 2'b00};
        end else begin
          w_rf_we_n    = 1'b1;
          w_rf_waddr_n = r_pend_reg;
          w_rf_wdata_n = i_mem_rdata;
        end
`else
        w_rf_we_n    = 1'b1;
        w_rf_waddr_n = r_pend_reg;
        w_rf_wdata_n = i_mem_rdata;
`endif
      end else begin
        w_mem_we_n    = 1'b1;
        w_mem_addr_n  = r_pend_addr;
        w_mem_wdata_n = i_rf_rdata;
      end
    end

    w_busy_n = (w_state_n != S_IDLE);
    w_done_n = (w_state_n == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_addr      <= '0;
      r_is_load   <= 1'b0;
      r_wb_en     <= 1'b0;
      r_base_reg  <= '0;
      r_wb_val    <= '0;
      r_pend      <= 1'b0;
      r_pend_reg  <= '0;
      r_pend_addr <= '0;
      r_rf_raddr  <= '0;
      r_rf_we     <= 1'b0;
      r_rf_waddr  <= '0;
      r_rf_wdata  <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef SEQ_PC_REDIRECT_EN
      r_pc_redir  <= 1'b0;
      r_pc_target <= '0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_mask      <= w_mask_n;
      r_addr      <= w_addr_n;
      r_is_load   <= w_is_load_n;
      r_wb_en     <= w_wb_en_n;
      r_base_reg  <= w_base_reg_n;
      r_wb_val    <= w_wb_val_n;
      r_pend      <= w_pend_n;
      r_pend_reg  <= w_pend_reg_n;
      r_pend_addr <= w_pend_addr_n;
      r_rf_raddr  <= w_rf_raddr_n;
      r_rf_we     <= w_rf_we_n;
      r_rf_waddr  <= w_rf_waddr_n;
      r_rf_wdata  <= w_rf_wdata_n;
      r_mem_re    <= w_mem_re_n;
      r_mem_we    <= w_mem_we_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_wdata <= w_mem_wdata_n;
      r_busy      <= w_busy_n;
      r_done      <= w_done_n;
`ifdef SEQ_PC_REDIRECT_EN
      r_pc_redir  <= w_pc_redir_n;
      r_pc_target <= w_pc_target_n;
`endif
    end
  end

  assign o_rf_raddr  = r_rf_raddr;
  assign o_rf_we     = r_rf_we;
  assign o_rf_waddr  = r_rf_waddr;
  assign o_rf_wdata  = r_rf_wdata;
  assign o_mem_re    = r_mem_re;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
`ifdef SEQ_PC_REDIRECT_EN
  assign o_pc_redir  = r_pc_redir;
  assign o_pc_target = r_pc_target;
`endif

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb_ldm_stm_sequencer: scoreboard bench for ldm_stm_sequencer.
// Register file and memory are modelled here; memory words are a function of address.
module tb_ldm_stm_sequencer;

  localparam logic [1:0] K_MEM = 2'd0;
  localparam logic [1:0] K_RF  = 2'd1;
  localparam logic [1:0] K_PC  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, is_load, pre, up, wback;
  logic [3:0]  base_reg;
  logic [31:0] base_val;
  logic [15:0] reg_list;
  logic [3:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, done;
`ifdef SEQ_PC_REDIRECT_EN
  logic        pc_redir;
  logic [31:0] pc_target;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_ev     = 0;

  ev_t         q_wr[$];
  logic [31:0] q_rd[$];
  ev_t         e;
  logic [31:0] ra;
  logic [31:0] rf [16];

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0000_0504) return 32'h0000_0407;
    return (a ^ 32'h5EED_0000) + 32'h3;
  endfunction

  assign rf_rdata  = rf[rf_raddr];
  assign mem_rdata = memword(mem_addr);

  always #5 clk = ~clk;

  ldm_stm_sequencer #(.AW(32), .DW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (start),
    .i_is_load  (is_load),
    .i_pre      (pre),
    .i_up       (up),
    .i_wback    (wback),
    .i_base_reg (base_reg),
    .i_base_val (base_val),
    .i_reg_list (reg_list),
    .o_rf_raddr (rf_raddr),
    .i_rf_rdata (rf_rdata),
    .o_rf_we    (rf_we),
    .o_rf_waddr (rf_waddr),
    .o_rf_wdata (rf_wdata),
    .o_mem_re   (mem_re),
    .o_mem_we   (mem_we),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata),
    .o_busy     (busy),
    .o_done     (done)
`ifdef SEQ_PC_REDIRECT_EN
    ,
    .o_pc_redir (pc_redir),
    .o_pc_target(pc_target)
`endif
  );

  // Scoreboard: every strobe pops and compares one expected event.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      n_ev++;
      n_checks++;
      if (q_wr.size() == 0) begin
        n_fail++;
        $display("FAIL sb_store unexpected addr=%h data=%h", mem_addr, mem_wdata);
      end else begin
        e = q_wr.pop_front();
        if ({e.kind, e.addr, e.data} !== {K_MEM, mem_addr, mem_wdata}) begin
          n_fail++;
          $display("FAIL sb_store got addr=%h data=%h want kind=%0d addr=%h data=%h",
                   mem_addr, mem_wdata, e.kind, e.addr, e.data);
        end
      end
    end
    if (rf_we === 1'b1) begin
      n_ev++;
      n_checks++;
      if (q_wr.size() == 0) begin
        n_fail++;
        $display("FAIL sb_rfwr unexpected r%0d=%h", rf_waddr, rf_wdata);
      end else begin
        e = q_wr.pop_front();
        if ({e.kind, e.addr, e.data} !== {K_RF, 28'd0, rf_waddr, rf_wdata}) begin
          n_fail++;
          $display("FAIL sb_rfwr got r%0d=%h want kind=%0d r%0d=%h",
                   rf_waddr, rf_wdata, e.kind, e.addr, e.data);
        end
      end
      rf[rf_waddr] = rf_wdata;
    end
    if (mem_re === 1'b1) begin
      n_ev++;
      n_checks++;
      if (q_rd.size() == 0) begin
        n_fail++;
        $display("FAIL sb_read unexpected addr=%h", mem_addr);
      end else begin
        ra = q_rd.pop_front();
        if (mem_addr !== ra) begin
          n_fail++;
          $display("FAIL sb_read got addr=%h want %h", mem_addr, ra);
        end
      end
    end
`ifdef SEQ_PC_REDIRECT_EN
    if (pc_redir === 1'b1) begin
      n_ev++;
      n_checks++;
      if (q_wr.size() == 0) begin
        n_fail++;
        $display("FAIL sb_pc unexpected target=%h", pc_target);
      end else begin
        e = q_wr.pop_front();
        if ({e.kind, e.data} !== {K_PC, pc_target}) begin
          n_fail++;
          $display("FAIL sb_pc got target=%h want kind=%0d target=%h",
                   pc_target, e.kind, e.data);
        end
      end
    end
`endif
  end

  // Pushes the expected events, starts the op at the current negedge and
  // returns cycles until done (-1 on timeout); ends in the following IDLE cycle.
  task automatic run_op(input logic ld, input logic p, input logic u,
                        input logic w, input logic [3:0] b,
                        input logic [15:0] lst, input bit hold,
                        output int lat, output logic bsy);
    int          n;
    logic [31:0] bv, s, a, t;
    bit          wben;
    bv = rf[b];
    n = 0;
    for (int i = 0; i < 16; i++) if (lst[i]) n++;
    case ({p, u})
      2'b01:   s = bv;
      2'b11:   s = bv + 32'd4;
      2'b00:   s = bv - 32'(4 * n) + 32'd4;
      default: s = bv - 32'(4 * n);
    endcase
    a = s;
    for (int i = 0; i < 16; i++) begin
      if (lst[i]) begin
        if (ld) begin
          q_rd.push_back(a);
          t = memword(a);
`ifdef SEQ_PC_REDIRECT_EN
          if (i == 15) q_wr.push_back({K_PC, 32'd0, {t[31:2], 2'b00}});
          else q_wr.push_back({K_RF, 32'(i), t});
`else
          q_wr.push_back({K_RF, 32'(i), t});
`endif
        end else begin
          q_wr.push_back({K_MEM, a, rf[i]});
        end
        a = a + 32'd4;
      end
    end
    wben = w && (n > 0) && !(ld && lst[b]);
    if (wben)
      q_wr.push_back({K_RF, 32'(b), u ? bv + 32'(4 * n) : bv - 32'(4 * n)});
    is_load = ld; pre = p; up = u; wback = w;
    base_reg = b; base_val = bv; reg_list = lst;
    start = 1'b1;
    lat = -1;
    bsy = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) start = 1'b0;
      if (done === 1'b1) begin
        lat = c;
        bsy = busy;
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0; is_load = 1'b0; pre = 1'b0; up = 1'b0; wback = 1'b0;
    base_reg = '0; base_val = '0; reg_list = '0;
    for (int i = 0; i < 16; i++) rf[i] = 32'hC0DE_0000 + 32'(i);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, rf_we, mem_we, mem_re} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes got %b want 00000", {busy, done, rf_we, mem_we, mem_re});
    end
    n_checks++;
    if ({rf_raddr, rf_waddr, mem_addr} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_addr got %h/%h/%h want 0", rf_raddr, rf_waddr, mem_addr);
    end
    n_checks++;
    if ({rf_wdata, mem_wdata} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_data got %h/%h want 0", rf_wdata, mem_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stm_ia();
    int lat; logic bsy;
    rf[13] = 32'h1000; rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33;
    run_op(1'b0, 1'b0, 1'b1, 1'b0, 4'd13, 16'h000E, 1'b0, lat, bsy);
    n_checks++;
    if (lat != 5) begin n_fail++; $display("FAIL stm_ia_latency got %0d want 5", lat); end
    n_checks++;
    if (q_wr.size() != 0) begin n_fail++; $display("FAIL stm_ia_pending got %0d want 0", q_wr.size()); end
    n_checks++;
    if (bsy !== 1'b1) begin n_fail++; $display("FAIL done_busy got %b want 1", bsy); end
    n_checks++;
    if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL idle_after_done got %b want 00", {busy, done}); end
  endtask

  task automatic test_ldm_db_wb();
    int lat; logic bsy;
    rf[0] = 32'h2000;
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 16'h0030, 1'b0, lat, bsy);
    n_checks++;
    if (lat != 5) begin n_fail++; $display("FAIL ldm_db_latency got %0d want 5", lat); end
    n_checks++;
    if (rf[0] !== 32'h1FF8) begin n_fail++; $display("FAIL ldm_db_wb got %h want 00001ff8", rf[0]); end
    n_checks++;
    if ({rf[4], rf[5]} !== {memword(32'h1FF8), memword(32'h1FFC)}) begin
      n_fail++; $display("FAIL ldm_db_data got %h %h", rf[4], rf[5]);
    end
    n_checks++;
    if (q_wr.size() + q_rd.size() != 0) begin n_fail++; $display("FAIL ldm_db_pending got %0d want 0", q_wr.size() + q_rd.size()); end
  endtask

  task automatic test_ldm_base_in_list();
    int lat; logic bsy;
    rf[2] = 32'h3000;
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 16'h0006, 1'b0, lat, bsy);
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL ldm_base_latency got %0d want 4", lat); end
    n_checks++;
    if (rf[2] !== memword(32'h3004)) begin n_fail++; $display("FAIL ldm_base_value got %h want %h", rf[2], memword(32'h3004)); end
    n_checks++;
    if (rf[1] !== memword(32'h3000)) begin n_fail++; $display("FAIL ldm_base_r1 got %h want %h", rf[1], memword(32'h3000)); end
  endtask

  task automatic test_empty();
    int lat, ev0; logic bsy;
    ev0 = n_ev;
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 16'h0000, 1'b0, lat, bsy);
    n_checks++;
    if (lat != 1) begin n_fail++; $display("FAIL empty_latency got %0d want 1", lat); end
    n_checks++;
    if (n_ev != ev0) begin n_fail++; $display("FAIL empty_activity got %0d events want 0", n_ev - ev0); end
  endtask

  task automatic test_modes();
    int lat; logic bsy;
    rf[5] = 32'h0800; rf[0] = 32'hA0; rf[8] = 32'hA8;
    run_op(1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 16'h0121, 1'b0, lat, bsy);
    n_checks++;
    if (lat != 6) begin n_fail++; $display("FAIL stm_ib_latency got %0d want 6", lat); end
    n_checks++;
    if (rf[5] !== 32'h080C) begin n_fail++; $display("FAIL stm_ib_wb got %h want 0000080c", rf[5]); end
    rf[7] = 32'h0900;
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 16'h0C00, 1'b0, lat, bsy);
    n_checks++;
    if (lat != 5) begin n_fail++; $display("FAIL ldm_da_latency got %0d want 5", lat); end
    n_checks++;
    if (rf[7] !== 32'h08F8) begin n_fail++; $display("FAIL ldm_da_wb got %h want 000008f8", rf[7]); end
  endtask

  task automatic test_wrap();
    int lat; logic bsy;
    rf[9] = 32'h4;
    run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 16'h0007, 1'b0, lat, bsy);
    n_checks++;
    if (lat != 6) begin n_fail++; $display("FAIL wrap_latency got %0d want 6", lat); end
    n_checks++;
    if (rf[9] !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_wb got %h want fffffff8", rf[9]); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; logic bsy;
    rf[6] = 32'h0700;
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 16'h0018, 1'b0, lat1, bsy);
    run_op(1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 16'h0018, 1'b1, lat2, bsy);
    n_checks++;
    if ({lat1, lat2} != {32'd4, 32'd4}) begin n_fail++; $display("FAIL b2b_latency got %0d,%0d want 4,4", lat1, lat2); end
    n_checks++;
    if (q_wr.size() + q_rd.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle got pending=%0d busy=%b want 0,0", q_wr.size() + q_rd.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic bsy;
    rf[12] = 32'h0600;
    for (int i = 0; i < 4; i++)
      q_wr.push_back({K_MEM, 32'h0600 + 32'(4 * i), rf[8 + i]});
    is_load = 1'b0; pre = 1'b0; up = 1'b1; wback = 1'b1;
    base_reg = 4'd12; base_val = rf[12]; reg_list = 16'h0F00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, mem_we} !== 2'b00) begin n_fail++; $display("FAIL rstmid_outputs got %b want 00", {busy, mem_we}); end
    n_checks++;
    if (q_wr.size() != 3) begin n_fail++; $display("FAIL rstmid_stores got %0d want 1", 4 - q_wr.size()); end
    reset = 1'b0;
    q_wr.delete();
    repeat (2) @(negedge clk);
    n_checks++;
    if (rf[12] !== 32'h0600) begin n_fail++; $display("FAIL rstmid_nowb got %h want 00000600", rf[12]); end
    run_op(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 16'h0000, 1'b0, lat, bsy);
    n_checks++;
    if (lat != 1) begin n_fail++; $display("FAIL rstmid_recover got %0d want 1", lat); end
  endtask

`ifdef SEQ_PC_REDIRECT_EN
  task automatic test_pc_redirect();
    int lat; logic bsy;
    rf[3] = 32'h0500; rf[15] = 32'hABCD;
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 16'h8001, 1'b0, lat, bsy);
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL pc_latency got %0d want 4", lat); end
    n_checks++;
    if ({rf[0], rf[15]} !== {memword(32'h0500), 32'hABCD}) begin
      n_fail++; $display("FAIL pc_regs got %h %h", rf[0], rf[15]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stm_ia();
    test_ldm_db_wb();
    test_ldm_base_in_list();
    test_empty();
    test_modes();
    test_wrap();
    test_back_to_back();
`ifdef SEQ_PC_REDIRECT_EN
    test_pc_redirect();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
- Multi-cycle load/store-multiple engine (LDM/STM) for the ARM-subset core.
- Acts as the initiator toward the register file: issues register reads (store) and register writes (load / base writeback), one register per cycle.
- Also drives the data-memory port.
- Sits beside the single-cycle datapath; the control unit stalls fetch while busy=1.

Parameters:
- AW, 32, memory address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- is_load  in  1  1=LDM, 0=STM.
- pre  in  1  P bit; 1=before, 0=after.
- up  in  1  U bit; 1=increment, 0=decrement.
- wback  in  1  W bit; base writeback enable.
- base_reg  in  4  base register index.
- base_val  in  DW  base register value.
- reg_list  in  16  register mask; bit i = Ri.
- rf_raddr  out  4  register-file read address.
- rf_rdata  in  DW  read data, valid one cycle after rf_raddr.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  4  register-file write address.
- rf_wdata  out  DW  register-file write data.
- mem_re  out  1  memory read strobe; mem_rdata valid next cycle.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  word address; bits[1:0]=0.
- mem_wdata  out  DW  store data.
- mem_rdata  in  DW  load data.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle completion pulse.
- pc_redir  out  1  only with SEQ_PC_REDIRECT_EN.
- pc_target  out  AW  only with SEQ_PC_REDIRECT_EN.

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs 0, including rf_raddr, rf_waddr and mem_addr.
  - Reset mid-operation aborts immediately; no further rf_we or mem_we.
- Outputs are all registered (change on posedge clk).
- States and transitions:
  - IDLE -> XFER on start; IDLE -> DONE if reg_list==0.
  - XFER -> WB or DONE.
  - WB -> DONE.
  - DONE -> IDLE.
  - start is ignored while busy.
- Accept: on the start edge, latch all request inputs and n = popcount(reg_list) (5 bits, 0..16).
- Start address S, computed modulo 2^32:
  - IA: base.
  - IB: base+4.
  - DA: base-4n+4.
  - DB: base-4n.
- Transfer order:
  - Ascending register index (lowest set bit first), at ascending addresses S, S+4, ...
  - The remaining mask clears one bit per issue.
- Pipeline: every cycle issues transfer k and completes transfer k-1, so n transfers take n+1 XFER cycles.
- STM:
  - Issue cycle: rf_raddr=Rk.
  - Complete cycle: mem_we=1, mem_addr=S+4k, mem_wdata=rf_rdata.
- LDM:
  - Issue cycle: mem_re=1, mem_addr=S+4k.
  - Complete cycle: rf_we=1, rf_waddr=Rk, rf_wdata=mem_rdata.
- rf_we and mem_we are never asserted for a register absent from reg_list.
- WB state (one cycle):
  - Entered only if wback=1, n>0, and NOT (is_load AND reg_list[base_reg]).
  - Drives rf_we=1, rf_waddr=base_reg, rf_wdata = base±4n (+ if up=1, - if up=0).
  - Loaded base value wins over writeback.
  - STM with base in the list stores the original base_val latched at accept.
- DONE: done=1 and busy=1 for one cycle, then IDLE. The next start can be accepted in the IDLE cycle that follows.
- Empty list (reg_list==0): IDLE -> DONE; no memory or register activity, no writeback.
- Address wrap: mem_addr wraps modulo 2^AW with no error.
- Total latency from start edge to done: n+1 (+1 if WB) +1 cycles.

Optional Feature:
- Macro: SEQ_PC_REDIRECT_EN.
- Defined:
  - An LDM completion for R15 does not assert rf_we.
  - Instead it pulses pc_redir=1 for that cycle with pc_target = {mem_rdata[AW-1:2],2'b00}.
  - pc_redir and pc_target reset to 0.
- Undefined:
  - The pc_redir and pc_target ports do not exist.
  - R15 is written through rf_we like any other register.

Test Plan:
- STM IA, base R13=0x1000, list=0x000E (R1..R3=0x11,0x22,0x33), W=0 -> mem_we at 0x1000/0x1004/0x1008 with data 0x11/0x22/0x33 in consecutive cycles; no rf_we; done 5 cycles after start.
- LDM DB, base R0=0x2000, list=0x0030, W=1 -> mem_re at 0x1FF8 then 0x1FFC; R4 loaded from 0x1FF8, R5 from 0x1FFC; WB writes R0=0x1FF8; done 5 cycles after start.
- LDM IA, W=1, base R2 included in list=0x0006 -> R1 and R2 loaded; no WB cycle; final R2 = memory value.
- reg_list=0x0000 with start -> done pulses 1 cycle after start; rf_we, mem_we and mem_re never assert.
- Reset asserted during the 2nd XFER cycle of a 4-register STM -> next cycle busy=0, mem_we=0; only 1 store was performed.
- With SEQ_PC_REDIRECT_EN, LDM list=0x8001, mem word for R15 = 0x00000407 -> R0 written; pc_redir pulses with pc_target=0x00000404; no rf_we to R15.
